game_state_controller: RTL and testbench
========================================

GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

Interface
REQ-001 Parameter NUM_BRICKS, default 8: brick count loaded at game start; legal range 1..255.
REQ-002 Parameter MAX_LIVES, default 3: number of misses that ends the game; legal range 1..3.
REQ-003 Parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before play; legal range 1..511.
REQ-004 Parameter END_FRAMES, default 180: frame ticks spent in WIN or LOSE before returning to IDLE; legal range 1..511.
REQ-005 Clk  in  1  system clock; one clock, all state on the rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 frame_clk  in  1  VGA vertical-sync frame marker, synchronous to Clk.
REQ-008 start_key  in  1  level; high while the start key is held.
REQ-009 brick_hit  in  1  one-Clk pulse; ball destroyed one brick.
REQ-010 ball_miss  in  1  one-Clk pulse; ball left the bottom edge.
REQ-011 ball_start  out  1  start-screen overlay enable.
REQ-012 wingame  out  1  win overlay enable.
REQ-013 lose  out  1  lose overlay enable.
REQ-014 lives_count  out  2  lives lost, 0..MAX_LIVES; 0 shows all hearts.
REQ-015 play_en  out  1  ball and paddle motion enable.
REQ-016 ball_serve  out  1  one-Clk pulse; ball returns to the serve position.

Function
REQ-017 All outputs are registered, Moore-style from state; no input reaches an output combinationally.
REQ-018 frame_tick is high for one Clk on each 0->1 transition of frame_clk, detected with one register stage.
REQ-019 start_edge is high for one Clk on each 0->1 transition of start_key; holding the key produces only one edge.
REQ-020 States are IDLE, SERVE, PLAY, WIN and LOSE; one-hot encoding is permitted.
REQ-021 IDLE: ball_start=1, play_en=0.
REQ-022 IDLE, on start_edge: enter SERVE, lives_count:=0, bricks_left:=NUM_BRICKS, timer:=0, and pulse ball_serve in the following cycle.
REQ-023 SERVE: play_en=0; the 9-bit timer increments on each frame_tick.
REQ-024 SERVE, on the tick that makes timer==SERVE_FRAMES: enter PLAY and clear timer.
REQ-025 PLAY: play_en=1.
REQ-026 PLAY, on brick_hit: bricks_left decrements and saturates at 0; if the result is 0, enter WIN and clear timer.
REQ-027 PLAY, on ball_miss: lives_count increments; if the new value equals MAX_LIVES, enter LOSE; otherwise enter SERVE, clear timer and pulse ball_serve.
REQ-028 brick_hit and ball_miss in the same cycle: both counters update; if the last brick was hit, WIN takes priority over LOSE or SERVE.
REQ-029 brick_hit and ball_miss are ignored in every state other than PLAY.
REQ-030 WIN: wingame=1. LOSE: lose=1. play_en=0 in both.
REQ-031 WIN or LOSE: timer counts frame ticks; exit to IDLE on timer==END_FRAMES or on start_edge, whichever occurs first.
REQ-032 lives_count holds its value through WIN, LOSE and IDLE; it is cleared only by Reset or by REQ-022.
REQ-033 At most one of ball_start, wingame and lose is high in any cycle.
REQ-034 A frame_tick and a state-exit event in the same cycle: the exit wins and timer clears.

Reset
REQ-035 When Reset=1 at a rising Clk edge, the block enters IDLE, clears timer, lives_count and bricks_left, and clears the frame_clk and start_key edge registers.
REQ-036 Reset values: ball_start=1; wingame, lose, play_en and ball_serve=0; lives_count=0.
REQ-037 Reset overrides every other input in the same cycle; a reset asserted mid-PLAY or mid-SERVE abandons the game without a ball_serve pulse.

Verification
REQ-038 Reset, then start_key 0->1 -> SERVE; ball_serve pulses once; play_en=1 exactly after SERVE_FRAMES=4 frame ticks.
REQ-039 In PLAY with NUM_BRICKS=2, two brick_hit pulses -> wingame=1 the cycle after the second; after END_FRAMES=3 ticks -> ball_start=1.
REQ-040 MAX_LIVES=3, three ball_miss pulses -> lives_count 1, 2, 3; ball_serve after the 1st and 2nd only; lose=1 after the 3rd.
REQ-041 Last brick_hit coincident with the third ball_miss -> wingame=1, lose=0, lives_count=3.
REQ-042 start_key held high for 1000 cycles from IDLE -> exactly one ball_serve pulse; brick_hit during SERVE -> bricks_left unchanged.
REQ-043 Reset asserted in PLAY with lives_count=2 -> next cycle ball_start=1, lives_count=0, play_en=0.

Source files
------------

// File: rtl/game_state_controller.sv
// Breakout-style game sequencer: start screen, serve delay, play, and win/lose screens.
// Outputs are registered from the next state, so each output is a pure decode of the current state.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | start screen shown, waiting for a start key press
//   ST_SERVE | ball parked at serve position, counting serve frames
//   ST_PLAY  | ball and paddle moving, bricks and misses counted
//   ST_WIN   | all bricks cleared, win screen for END_FRAMES frames
//   ST_LOSE  | out of lives, lose screen for END_FRAMES frames
module game_state_controller #(
  parameter int NUM_BRICKS   = 8,
  parameter int MAX_LIVES    = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int END_FRAMES   = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       brick_hit,
  input  logic       ball_miss,
  output logic       ball_start,
  output logic       wingame,
  output logic       lose,
  output logic [1:0] lives_count,
  output logic       play_en,
  output logic       ball_serve
);

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SERVE = 5'b00010,
    ST_PLAY  = 5'b00100,
    ST_WIN   = 5'b01000,
    ST_LOSE  = 5'b10000
  } state_t;

  localparam logic [7:0] BRICKS_INIT = 8'(NUM_BRICKS);
  localparam logic [1:0] LIVES_MAX   = 2'(MAX_LIVES);
  localparam logic [8:0] SERVE_LAST  = 9'(SERVE_FRAMES);
  localparam logic [8:0] END_LAST    = 9'(END_FRAMES);

  state_t     state, state_nx;
  logic [8:0] timer, timer_nx, timer_inc;
  logic [7:0] bricks_left, bricks_nx;
  logic [1:0] lives_nx;
  logic       serve_nx;
  logic       frame_clk_q, start_key_q;
  logic       frame_tick, start_edge;

  assign frame_tick = frame_clk & ~frame_clk_q;
  assign start_edge = start_key & ~start_key_q;
  assign timer_inc  = timer + 9'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      bricks_left <= '0;
      lives_count <= '0;
      frame_clk_q <= 1'b0;
      start_key_q <= 1'b0;
      ball_start  <= 1'b1;
      wingame     <= 1'b0;
      lose        <= 1'b0;
      play_en     <= 1'b0;
      ball_serve  <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      bricks_left <= bricks_nx;
      lives_count <= lives_nx;
      frame_clk_q <= frame_clk;
      start_key_q <= start_key;
      ball_start  <= (state_nx == ST_IDLE);
      wingame     <= (state_nx == ST_WIN);
      lose        <= (state_nx == ST_LOSE);
      play_en     <= (state_nx == ST_PLAY);
      ball_serve  <= serve_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    bricks_nx = bricks_left;
    lives_nx  = lives_count;
    serve_nx  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nx  = ST_SERVE;
          timer_nx  = '0;
          bricks_nx = BRICKS_INIT;
          lives_nx  = '0;
          serve_nx  = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (timer_inc == SERVE_LAST) begin
            state_nx = ST_PLAY;
            timer_nx = '0;
          end else begin
            timer_nx = timer_inc;
          end
        end
      end
      ST_PLAY: begin
        if (brick_hit && (bricks_left != 8'd0))
          bricks_nx = bricks_left - 8'd1;
        if (ball_miss)
          lives_nx = lives_count + 2'd1;
        // Clearing the last brick wins even if the same cycle costs the final life.
        if (brick_hit && (bricks_nx == 8'd0)) begin
          state_nx = ST_WIN;
          timer_nx = '0;
        end else if (ball_miss) begin
          timer_nx = '0;
          if (lives_nx == LIVES_MAX) begin
            state_nx = ST_LOSE;
          end else begin
            state_nx = ST_SERVE;
            serve_nx = 1'b1;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_edge) begin
          state_nx = ST_IDLE;
          timer_nx = '0;
        end else if (frame_tick) begin
          if (timer_inc == END_LAST) begin
            state_nx = ST_IDLE;
            timer_nx = '0;
          end else begin
            timer_nx = timer_inc;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        timer_nx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench: a driver pushes per-cycle expected outputs from a game-rules model,
// and a monitor pops and compares them one time unit after each rising edge.
module tb_game_state_controller;

  localparam int NB = 2;
  localparam int ML = 3;
  localparam int SF = 4;
  localparam int EF = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       start_key = 1'b0;
  logic       brick_hit = 1'b0;
  logic       ball_miss = 1'b0;
  logic       ball_start, wingame, lose, play_en, ball_serve;
  logic [1:0] lives_count;

  game_state_controller #(
    .NUM_BRICKS(NB), .MAX_LIVES(ML), .SERVE_FRAMES(SF), .END_FRAMES(EF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .brick_hit(brick_hit), .ball_miss(ball_miss), .ball_start(ball_start),
    .wingame(wingame), .lose(lose), .lives_count(lives_count),
    .play_en(play_en), .ball_serve(ball_serve)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit bs, wg, ls, pe, sv;
    int lives;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  // Game-rules model: screen name, bricks destroyed, balls lost, frames elapsed on this screen.
  string g_screen = "start";
  int    g_hits = 0, g_lost = 0, g_frames = 0;
  bit    g_serve = 0, g_prev_f = 0, g_prev_k = 0;

  task automatic check(string name, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(bit r, bit f, bit k, bit h, bit m);
    bit tick, press;
    exp_t e;
    @(negedge Clk);
    Reset = r; frame_clk = f; start_key = k; brick_hit = h; ball_miss = m;
    tick = f && !g_prev_f;
    press = k && !g_prev_k;
    g_serve = 0;
    if (r) begin
      g_screen = "start"; g_hits = 0; g_lost = 0; g_frames = 0;
      g_prev_f = 0; g_prev_k = 0;
    end else begin
      if (g_screen == "start") begin
        if (press) begin
          g_screen = "serve"; g_hits = 0; g_lost = 0; g_frames = 0; g_serve = 1;
        end
      end else if (g_screen == "serve") begin
        if (tick) g_frames++;
        if (g_frames == SF) begin g_screen = "play"; g_frames = 0; end
      end else if (g_screen == "play") begin
        if (h && g_hits < NB) g_hits++;
        if (m) g_lost++;
        if (h && g_hits == NB) begin
          g_screen = "win"; g_frames = 0;
        end else if (m) begin
          g_frames = 0;
          if (g_lost == ML) g_screen = "lose";
          else begin g_screen = "serve"; g_serve = 1; end
        end
      end else begin
        if (press) begin
          g_screen = "start"; g_frames = 0;
        end else begin
          if (tick) g_frames++;
          if (g_frames == EF) begin g_screen = "start"; g_frames = 0; end
        end
      end
      g_prev_f = f;
      g_prev_k = k;
    end
    e.bs = (g_screen == "start");
    e.wg = (g_screen == "win");
    e.ls = (g_screen == "lose");
    e.pe = (g_screen == "play");
    e.sv = g_serve;
    e.lives = g_lost;
    sb.push_back(e);
  endtask

  always @(posedge Clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ball_start", int'(ball_start), int'(e.bs));
      check("wingame", int'(wingame), int'(e.wg));
      check("lose", int'(lose), int'(e.ls));
      check("play_en", int'(play_en), int'(e.pe));
      check("ball_serve", int'(ball_serve), int'(e.sv));
      check("lives_count", int'(lives_count), e.lives);
      n_checks++;
      if (int'(ball_start) + int'(wingame) + int'(lose) > 1) begin
        n_fail++;
        $display("FAIL overlay_onehot: got %0d%0d%0d required at most one high",
                 ball_start, wingame, lose);
      end
    end
  end

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic frames(int n);
    repeat (n) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic press;
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic hit;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic miss;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit f_lvl, k_lvl;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(3);

    // Start key held for 1000 cycles with a stray brick hit while serving.
    for (int i = 0; i < 1000; i++) step(0, 0, 1, (i == 500), 0);
    idle(2);
    frames(SF);
    idle(2);
    hit();
    hit();
    frames(EF);
    idle(2);

    // Three misses to a loss, exited early by the start key.
    press();
    frames(SF); miss();
    frames(SF); miss();
    frames(SF); miss();
    idle(2);
    press();
    idle(2);

    // Last brick coincident with the final miss.
    press();
    frames(SF); miss();
    frames(SF); miss();
    frames(SF); hit();
    step(0, 0, 0, 1, 1);
    idle(2);
    frames(EF);

    // Reset mid-play with two lives lost.
    press();
    frames(SF); miss();
    frames(SF); miss();
    frames(SF);
    step(1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 1);
    idle(2);

    f_lvl = 0;
    k_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) f_lvl = !f_lvl;
      if ($urandom_range(0, 39) == 0) k_lvl = !k_lvl;
      step(($urandom_range(0, 499) == 0), f_lvl, k_lvl,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(2);

    @(posedge Clk);
    #2;
    check("queue_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
